ball_motion_ctrl: RTL and testbench

Per-frame motion controller for the ball spot. Updates the ball's horizontal and vertical position once per video frame and reverses direction on player or wall coincidence. Detects misses and sequences serve/run/out states. Its position and enable outputs drive the ball spot generator's position inputs and enable; its hit inputs come from coincidence of the ball spot with the player and wall spots.

---
 rtl/odyssey_pkg.sv | 14 +
 rtl/spot_axis_step.sv | 51 +++++
 rtl/ball_motion_ctrl.sv | 155 +++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/odyssey_pkg.sv
// Shared definitions for the odyssey ball/spot blocks.
//   POS_W        : width of spot position coordinates.
//   ball_state_t : ball motion states (serve wait, in play, out of play).
package odyssey_pkg;

    localparam int POS_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } ball_state_t;

endpackage

// File: rtl/spot_axis_step.sv
// Combinational add-and-clamp along one screen axis.
//   i_pos     : current position (unsigned)
//   i_step    : step magnitude; zero- or sign-extended per STEP_SIGNED
//   i_neg     : 1 = subtract the step instead of adding it
//   o_pos     : pos +/- step, clamped into [MIN, MAX]
//   o_clamped : 1 when the raw result fell outside [MIN, MAX]
import odyssey_pkg::*;

module spot_axis_step #(
    parameter int               STEP_W      = 3,
    parameter bit               STEP_SIGNED = 1'b0,
    parameter logic [POS_W-1:0] MIN         = '0,
    parameter logic [POS_W-1:0] MAX         = '1
) (
    input  logic [POS_W-1:0]  i_pos,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_neg,
    output logic [POS_W-1:0]  o_pos,
    output logic              o_clamped
);

    // Two spare bits give headroom for both overflow past MAX and
    // underflow below zero without wrapping.
    localparam int SUM_W = POS_W + 2;
    localparam logic signed [SUM_W-1:0] L_MIN = {2'b00, MIN};
    localparam logic signed [SUM_W-1:0] L_MAX = {2'b00, MAX};

    logic signed [SUM_W-1:0] w_step;
    logic signed [SUM_W-1:0] w_sum;

    always_comb begin
        if (STEP_SIGNED)
            w_step = {{(SUM_W-STEP_W){i_step[STEP_W-1]}}, i_step};
        else
            w_step = {{(SUM_W-STEP_W){1'b0}}, i_step};
        if (i_neg)
            w_step = -w_step;
        w_sum = $signed({2'b00, i_pos}) + w_step;

        o_pos     = w_sum[POS_W-1:0];
        o_clamped = 1'b0;
        if (w_sum < L_MIN) begin
            o_pos     = MIN;
            o_clamped = 1'b1;
        end else if (w_sum > L_MAX) begin
            o_pos     = MAX;
            o_clamped = 1'b1;
        end
    end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion controller. Steps the ball once per frame_tick,
// reverses on player/wall coincidence, detects misses and sequences
// IDLE (waiting for serve) -> RUN -> OUT -> IDLE.
//   clk, reset            : clock, synchronous active-high reset
//   frame_tick            : one-cycle pulse per frame (vertical blank)
//   enable                : 0 freezes all state
//   serve                 : serve request level
//   hit_left/right/wall   : coincidence of ball with player/wall spots
//   h_speed               : unsigned horizontal pixels per frame
//   english               : signed vertical pixels per frame
//   ball_h_pos/ball_v_pos : ball position to the spot generator
//   ball_enable           : spot generator enable, high only in RUN
//   dir_right             : current horizontal direction
//   miss_left/miss_right  : one-cycle pulse when the ball exits a side
import odyssey_pkg::*;

module ball_motion_ctrl #(
    parameter logic [POS_W-1:0] H_MIN   = 10'd16,
    parameter logic [POS_W-1:0] H_MAX   = 10'd560,
    parameter logic [POS_W-1:0] V_MIN   = 10'd16,
    parameter logic [POS_W-1:0] V_MAX   = 10'd240,
    parameter logic [POS_W-1:0] H_START = 10'd288,
    parameter logic [POS_W-1:0] V_START = 10'd128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             enable,
    input  logic             serve,
    input  logic             hit_left,
    input  logic             hit_right,
    input  logic             hit_wall,
    input  logic [2:0]       h_speed,
    input  logic [3:0]       english,
    output logic [POS_W-1:0] ball_h_pos,
    output logic [POS_W-1:0] ball_v_pos,
    output logic             ball_enable,
    output logic             dir_right,
    output logic             miss_left,
    output logic             miss_right
);

    ball_state_t      r_state;
    logic [POS_W-1:0] r_h, r_v;
    logic             r_dir, r_serve_dir, r_ball_en;
    logic             r_miss_l, r_miss_r;
    logic             r_hit_l, r_hit_r, r_hit_w;

    logic             w_hit_l, w_hit_r, w_hit_w;
    logic             w_dir_next;
    logic [POS_W-1:0] w_h_step, w_v_step;
    logic             w_h_clamped, w_v_clamped;
    logic             w_miss_l, w_miss_r;

    // A hit seen on the tick cycle itself still belongs to the closing frame.
    assign w_hit_l = r_hit_l | hit_left;
    assign w_hit_r = r_hit_r | hit_right;
    assign w_hit_w = r_hit_w | hit_wall;

    // Direction for this frame's step. On serve the ball heads away from
    // the side that last missed; in play a player hit only counts when it
    // actually reverses the ball, and it beats a wall hit.
    always_comb begin
        w_dir_next = r_dir;
        if (r_state == IDLE)
            w_dir_next = r_serve_dir;
        else if (w_hit_l && !r_dir)
            w_dir_next = 1'b1;
        else if (w_hit_r && r_dir)
            w_dir_next = 1'b0;
        else if (w_hit_w)
            w_dir_next = ~r_dir;
    end

    spot_axis_step #(
        .STEP_W(3), .STEP_SIGNED(1'b0), .MIN(H_MIN), .MAX(H_MAX)
    ) u_h_step (
        .i_pos(r_h), .i_step(h_speed), .i_neg(~w_dir_next),
        .o_pos(w_h_step), .o_clamped(w_h_clamped)
    );

    // Vertical clamping is the boundary behaviour; there is no bounce.
    spot_axis_step #(
        .STEP_W(4), .STEP_SIGNED(1'b1), .MIN(V_MIN), .MAX(V_MAX)
    ) u_v_step (
        .i_pos(r_v), .i_step(english), .i_neg(1'b0),
        .o_pos(w_v_step), .o_clamped(w_v_clamped)
    );

    // Horizontal clamping can only happen on the side we are moving toward.
    assign w_miss_r = w_h_clamped &  w_dir_next;
    assign w_miss_l = w_h_clamped & ~w_dir_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_h         <= H_START;
            r_v         <= V_START;
            r_dir       <= 1'b1;
            r_serve_dir <= 1'b1;
            r_ball_en   <= 1'b0;
            r_miss_l    <= 1'b0;
            r_miss_r    <= 1'b0;
            r_hit_l     <= 1'b0;
            r_hit_r     <= 1'b0;
            r_hit_w     <= 1'b0;
        end else begin
            // Miss pulses last one cycle even if enable drops right after.
            r_miss_l <= 1'b0;
            r_miss_r <= 1'b0;
            if (enable) begin
                if (frame_tick) begin
                    r_hit_l <= 1'b0;
                    r_hit_r <= 1'b0;
                    r_hit_w <= 1'b0;
                    if (r_state == RUN || (r_state == IDLE && serve)) begin
                        r_dir <= w_dir_next;
                        r_h   <= w_h_step;
                        r_v   <= w_v_step;
                        if (w_miss_r) begin
                            r_state     <= OUT;
                            r_ball_en   <= 1'b0;
                            r_miss_r    <= 1'b1;
                            r_serve_dir <= 1'b0;
                        end else if (w_miss_l) begin
                            r_state     <= OUT;
                            r_ball_en   <= 1'b0;
                            r_miss_l    <= 1'b1;
                            r_serve_dir <= 1'b1;
                        end else begin
                            r_state   <= RUN;
                            r_ball_en <= 1'b1;
                        end
                    end else if (r_state == OUT && !serve) begin
                        r_state <= IDLE;
                        r_h     <= H_START;
                        r_v     <= V_START;
                    end
                end else begin
                    r_hit_l <= r_hit_l | hit_left;
                    r_hit_r <= r_hit_r | hit_right;
                    r_hit_w <= r_hit_w | hit_wall;
                end
            end
        end
    end

    assign ball_h_pos  = r_h;
    assign ball_v_pos  = r_v;
    assign ball_enable = r_ball_en;
    assign dir_right   = r_dir;
    assign miss_left   = r_miss_l;
    assign miss_right  = r_miss_r;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
module tb_ball_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0, frame_tick = 1'b0, enable = 1'b0, serve = 1'b0;
    logic       hit_left = 1'b0, hit_right = 1'b0, hit_wall = 1'b0;
    logic [2:0] h_speed = '0;
    logic [3:0] english = '0;
    logic [9:0] ball_h_pos, ball_v_pos;
    logic       ball_enable, dir_right, miss_left, miss_right;

    int n_cmp = 0;
    int n_err = 0;

    ball_motion_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .serve(serve), .hit_left(hit_left), .hit_right(hit_right),
        .hit_wall(hit_wall), .h_speed(h_speed), .english(english),
        .ball_h_pos(ball_h_pos), .ball_v_pos(ball_v_pos),
        .ball_enable(ball_enable), .dir_right(dir_right),
        .miss_left(miss_left), .miss_right(miss_right)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst, tick, en, srv, hl, hr, hw;
        logic [2:0] spd;
        logic [3:0] eng;
        int         eh, ev;
        bit         een, edir, eml, emr;
    } vec_t;

    vec_t tbl[$];

    function automatic void row(bit rst, bit tick, bit en, bit srv, bit hl, bit hr, bit hw,
                                int spd, int eng, int eh, int ev,
                                bit een, bit edir, bit eml, bit emr);
        vec_t r;
        r.rst = rst; r.tick = tick; r.en = en; r.srv = srv;
        r.hl = hl; r.hr = hr; r.hw = hw;
        r.spd = 3'(spd); r.eng = 4'(eng);
        r.eh = eh; r.ev = ev; r.een = een; r.edir = edir; r.eml = eml; r.emr = emr;
        tbl.push_back(r);
    endfunction

    // Enabled frame tick with serve held high, the common case in play.
    function automatic void tk(bit hl, bit hr, bit hw, int spd, int eng,
                               int eh, int ev, bit een, bit edir, bit eml, bit emr);
        row(0, 1, 1, 1, hl, hr, hw, spd, eng, eh, ev, een, edir, eml, emr);
    endfunction

    task automatic drive(input bit rst, input bit tick, input bit en, input bit srv,
                         input bit hl, input bit hr, input bit hw,
                         input logic [2:0] spd, input logic [3:0] eng);
        reset = rst; frame_tick = tick; enable = en; serve = srv;
        hit_left = hl; hit_right = hr; hit_wall = hw;
        h_speed = spd; english = eng;
    endtask

    task automatic check(input string nm, input int idx, input int eh, input int ev,
                         input bit een, input bit edir, input bit eml, input bit emr);
        n_cmp++;
        if (int'(ball_h_pos) !== eh || int'(ball_v_pos) !== ev || ball_enable !== een ||
            dir_right !== edir || miss_left !== eml || miss_right !== emr) begin
            n_err++;
            $display("FAIL %s[%0d]: got h=%0d v=%0d en=%b dir=%b ml=%b mr=%b, want h=%0d v=%0d en=%b dir=%b ml=%b mr=%b",
                     nm, idx, ball_h_pos, ball_v_pos, ball_enable, dir_right, miss_left, miss_right,
                     eh, ev, een, edir, eml, emr);
        end
    endtask

    // Reference model: frame-level behaviour in plain integers.
    int m_st;            // 0 waiting for serve, 1 in play, 2 out of play
    int m_h, m_v;
    bit m_dir, m_sdir, m_en, m_ml, m_mr, m_ll, m_lr, m_lw;

    task automatic m_reset();
        m_st = 0; m_h = 288; m_v = 128; m_dir = 1; m_sdir = 1;
        m_en = 0; m_ml = 0; m_mr = 0; m_ll = 0; m_lr = 0; m_lw = 0;
    endtask

    task automatic m_move(input int spd, input int eng);
        int nh, nv;
        nh = m_dir ? m_h + spd : m_h - spd;
        m_st = 1;
        if (nh > 560)     begin m_h = 560; m_mr = 1; m_st = 2; m_sdir = 0; end
        else if (nh < 16) begin m_h = 16;  m_ml = 1; m_st = 2; m_sdir = 1; end
        else m_h = nh;
        nv = m_v + eng;
        m_v = (nv < 16) ? 16 : (nv > 240) ? 240 : nv;
    endtask

    task automatic m_edge(input bit rst, input bit tick, input bit en, input bit srv,
                          input bit hl, input bit hr, input bit hw,
                          input logic [2:0] spd, input logic [3:0] eng);
        bit fl, fr, fw;
        int e;
        e = $signed(eng);
        m_ml = 0; m_mr = 0;
        if (rst) m_reset();
        else if (en) begin
            if (tick) begin
                fl = m_ll | hl; fr = m_lr | hr; fw = m_lw | hw;
                m_ll = 0; m_lr = 0; m_lw = 0;
                if (m_st == 0) begin
                    if (srv) begin m_dir = m_sdir; m_move(int'(spd), e); end
                end else if (m_st == 1) begin
                    if (fl && !m_dir)     m_dir = 1;
                    else if (fr && m_dir) m_dir = 0;
                    else if (fw)          m_dir = !m_dir;
                    m_move(int'(spd), e);
                end else if (!srv) begin
                    m_st = 0; m_h = 288; m_v = 128;
                end
            end else begin
                m_ll |= hl; m_lr |= hr; m_lw |= hw;
            end
        end
        m_en = (m_st == 1);
    endtask

    initial begin
        int h, v;
        bit r_rst, r_tick, r_en, r_srv, r_hl, r_hr, r_hw;
        logic [2:0] r_spd;
        logic [3:0] r_eng;

        // ---- directed vectors ----
        row(1, 0, 1, 0, 0, 0, 0, 0, 0, 288, 128, 0, 1, 0, 0);         // reset state
        tk(0, 0, 0, 3, 0, 291, 128, 1, 1, 0, 0);                      // serve
        h = 291;
        for (int k = 0; k < 15; k++) begin h += 7; tk(0, 0, 0, 7, 0, h, 128, 1, 1, 0, 0); end
        tk(0, 0, 0, 2, 0, 398, 128, 1, 1, 0, 0);
        tk(0, 0, 0, 2, 0, 400, 128, 1, 1, 0, 0);
        row(0, 0, 1, 1, 0, 1, 0, 2, 0, 400, 128, 1, 1, 0, 0);         // hit_right mid-frame
        row(0, 0, 1, 1, 0, 0, 0, 2, 0, 400, 128, 1, 1, 0, 0);
        tk(0, 0, 0, 2, 0, 398, 128, 1, 0, 0, 0);                      // reversed
        tk(0, 0, 0, 2, 0, 396, 128, 1, 0, 0, 0);
        h = 396;
        for (int k = 0; k < 42; k++) begin h -= 7; tk(0, 0, 0, 7, 0, h, 128, 1, 0, 0, 0); end
        tk(0, 0, 0, 2, 0, 100, 128, 1, 0, 0, 0);
        row(0, 0, 1, 1, 1, 0, 0, 4, 0, 100, 128, 1, 0, 0, 0);         // hit_left mid-frame
        tk(0, 0, 1, 4, 0, 104, 128, 1, 1, 0, 0);                      // + wall on tick: one reversal
        tk(0, 0, 1, 4, 0, 100, 128, 1, 0, 0, 0);                      // wall alone toggles
        tk(0, 0, 0, 4, 0, 96, 128, 1, 0, 0, 0);                       // latches cleared
        v = 128;
        for (int k = 0; k < 13; k++) begin v -= 8; tk(0, 0, 0, 0, -8, 96, v, 1, 0, 0, 0); end
        tk(0, 0, 0, 0, -4, 96, 20, 1, 0, 0, 0);
        tk(0, 0, 0, 0, -8, 96, 16, 1, 0, 0, 0);                       // clamp to V_MIN
        v = 16;
        for (int k = 0; k < 31; k++) begin v += 7; tk(0, 0, 0, 0, 7, 96, v, 1, 0, 0, 0); end
        tk(0, 0, 0, 0, 3, 96, 236, 1, 0, 0, 0);
        tk(0, 0, 0, 0, 7, 96, 240, 1, 0, 0, 0);                       // clamp to V_MAX
        tk(0, 0, 1, 0, 0, 96, 240, 1, 1, 0, 0);                       // speed 0, wall turns right
        h = 96;
        for (int k = 0; k < 66; k++) begin h += 7; tk(0, 0, 0, 7, 0, h, 240, 1, 1, 0, 0); end
        tk(0, 0, 0, 3, 0, 560, 240, 0, 1, 0, 1);                      // miss right
        row(0, 0, 1, 1, 0, 0, 0, 3, 0, 560, 240, 0, 1, 0, 0);         // pulse gone
        tk(0, 0, 0, 3, 0, 560, 240, 0, 1, 0, 0);                      // serve still high: stay OUT
        row(0, 1, 1, 0, 0, 0, 0, 3, 0, 288, 128, 0, 1, 0, 0);         // -> IDLE
        tk(0, 0, 0, 3, 0, 285, 128, 1, 0, 0, 0);                      // serve leftward
        row(0, 0, 0, 1, 1, 1, 1, 3, 0, 285, 128, 1, 0, 0, 0);         // frozen
        for (int k = 0; k < 3; k++) row(0, 1, 0, 1, 1, 1, 1, 3, 5, 285, 128, 1, 0, 0, 0);
        tk(0, 0, 0, 3, 0, 282, 128, 1, 0, 0, 0);                      // no hit was latched
        row(1, 1, 1, 1, 0, 0, 1, 3, 0, 288, 128, 0, 1, 0, 0);         // reset mid-RUN
        tk(0, 0, 0, 7, 0, 295, 128, 1, 1, 0, 0);
        tk(0, 0, 1, 7, 0, 288, 128, 1, 0, 0, 0);
        h = 288;
        for (int k = 0; k < 38; k++) begin h -= 7; tk(0, 0, 0, 7, 0, h, 128, 1, 0, 0, 0); end
        tk(0, 0, 0, 7, 0, 16, 128, 0, 0, 1, 0);                       // miss left
        tk(0, 0, 0, 7, 0, 16, 128, 0, 0, 0, 0);
        row(0, 1, 1, 0, 0, 0, 0, 7, 0, 288, 128, 0, 0, 0, 0);
        tk(0, 0, 0, 7, 0, 295, 128, 1, 1, 0, 0);                      // serve rightward

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].tick, tbl[i].en, tbl[i].srv,
                  tbl[i].hl, tbl[i].hr, tbl[i].hw, tbl[i].spd, tbl[i].eng);
            @(posedge clk);
            #1;
            check("vec", i, tbl[i].eh, tbl[i].ev, tbl[i].een, tbl[i].edir, tbl[i].eml, tbl[i].emr);
        end

        // ---- randomized against the reference model ----
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        m_edge(1, 0, 1, 0, 0, 0, 0, 0, 0);
        #1;
        for (int i = 0; i < 5000; i++) begin
            r_rst  = ($urandom_range(0, 799) == 0);
            r_tick = ($urandom_range(0, 2) == 0);
            r_en   = ($urandom_range(0, 9) != 0);
            r_srv  = ($urandom_range(0, 4) != 0);
            r_hl   = ($urandom_range(0, 24) == 0);
            r_hr   = ($urandom_range(0, 24) == 0);
            r_hw   = ($urandom_range(0, 29) == 0);
            r_spd  = 3'($urandom_range(0, 7));
            r_eng  = 4'($urandom_range(0, 15));
            drive(r_rst, r_tick, r_en, r_srv, r_hl, r_hr, r_hw, r_spd, r_eng);
            @(posedge clk);
            m_edge(r_rst, r_tick, r_en, r_srv, r_hl, r_hr, r_hw, r_spd, r_eng);
            #1;
            check("rand", i, m_h, m_v, m_en, m_dir, m_ml, m_mr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
